// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   // Last-granted pointer starts at the top index so index 0 wins first.
   function automatic int rr_ptr_rst(input int n_req);
      return n_req - 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req searching from base+1.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int N_REQ_l = 2
) (
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ_l-1:0] base,
   output logic [N_REQ_l-1:0] gnt_id,
   output logic               gnt_any
);

   logic [N_REQ_l-1:0] idx;

   // Walk farthest-first so the nearest hit overwrites earlier ones.
   always_comb begin
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = base + N_REQ_l'(i);
         if (req[idx]) begin
            gnt_id  = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single-clock FIFO.
// Packet lock is compiled in with FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int N_REQ_l = 2,
   parameter int WIDTH   = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   input  logic [N_REQ-1:0]         req_last,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr,
   output logic [WIDTH-1:0]         fifo_din,
   output logic [N_REQ_l-1:0]       grant_id,
   output logic                     grant_valid
);

   localparam logic [N_REQ_l-1:0] RR_RST =
      N_REQ_l'(rr_ptr_rst(N_REQ));

   logic [N_REQ_l-1:0] rr_ptr;
   logic [N_REQ_l-1:0] rr_next;
   logic [N_REQ_l-1:0] g;
   logic               g_any;
   logic               xfer;
   logic [N_REQ-1:0]   elig;

`ifdef FIFO_ARB_LOCK_EN
   arb_state_t         state;
   arb_state_t         state_next;
   logic [N_REQ_l-1:0] lock_id;
   logic [N_REQ_l-1:0] lock_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ARB_IDLE;
         lock_id <= '0;
         rr_ptr  <= RR_RST;
      end else begin
         state   <= state_next;
         lock_id <= lock_next;
         rr_ptr  <= rr_next;
      end
   end

   // While locked only the packet owner may be granted.
   always_comb begin
      elig = req_valid;
      if (state == ARB_LOCK)
         elig = req_valid & (N_REQ'(1) << lock_id);
   end

   always_comb begin
      state_next = state;
      lock_next  = lock_id;
      rr_next    = rr_ptr;
      if (xfer) begin
         unique case (state)
            ARB_IDLE: begin
               if (req_last[g]) begin
                  rr_next = g;
               end else begin
                  state_next = ARB_LOCK;
                  lock_next  = g;
               end
            end
            ARB_LOCK: begin
               if (req_last[g]) begin
                  state_next = ARB_IDLE;
                  rr_next    = lock_id;
               end
            end
            default: state_next = ARB_IDLE;
         endcase
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;

   always_ff @(posedge clock) begin
      if (reset)
         rr_ptr <= RR_RST;
      else
         rr_ptr <= rr_next;
   end

   assign elig = req_valid;

   always_comb begin
      rr_next = rr_ptr;
      if (xfer)
         rr_next = g;
   end
`endif

   rr_pick #(
      .N_REQ   (N_REQ),
      .N_REQ_l (N_REQ_l)
   ) u_pick (
      .req     (elig),
      .base    (rr_ptr),
      .gnt_id  (g),
      .gnt_any (g_any)
   );

   assign xfer = ~reset & ~fifo_full & g_any;

   always_comb begin
      req_ready   = '0;
      fifo_wr     = 1'b0;
      fifo_din    = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      if (xfer) begin
         req_ready[g] = 1'b1;
         fifo_wr      = 1'b1;
         fifo_din     = req_data[g*WIDTH +: WIDTH];
         grant_id     = g;
         grant_valid  = 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, random model, corner sequences.
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           fifo_full;
   logic           fifo_wr;
   logic [W-1:0]   fifo_din;
   logic [1:0]     grant_id;
   logic           grant_valid;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] pdata [N];

   fifo_wr_arbiter #(.N_REQ(N), .N_REQ_l(2), .WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wr     (fifo_wr),
      .fifo_din    (fifo_din),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   always #5 clock = ~clock;

   always_comb
      for (int i = 0; i < N; i++)
         req_data[i*W +: W] = pdata[i];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One cycle with fixed data 0x10+i; expected ready/gid given.
   task automatic step(input string nm, input logic [3:0] v,
                       input logic [3:0] l, input logic f,
                       input logic [3:0] er, input logic [1:0] eg);
      for (int i = 0; i < N; i++) pdata[i] = 8'h10 + 8'(i);
      req_valid = v;
      req_last  = l;
      fifo_full = f;
      #2;
      chk({nm, " ready"}, 32'(req_ready), 32'(er));
      chk({nm, " wr"}, 32'(fifo_wr), 32'(|er));
      chk({nm, " gvalid"}, 32'(grant_valid), 32'(|er));
      chk({nm, " gid"}, 32'(grant_id), 32'(|er ? eg : 2'd0));
      chk({nm, " din"}, 32'(fifo_din),
          32'(|er ? 8'h10 + 8'(eg) : 8'h00));
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step("reset", 4'b1111, 4'b1111, 1'b0, 4'b0000, 2'd0);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] v;
      logic       f;
      logic [3:0] er;
      logic [1:0] eg;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int m_ptr;
      int eg;
      int writes;
      logic [W-1:0] q [$];
      logic [3:0] v;
      logic f;
      logic [3:0] er;
      logic [W-1:0] ed;

      tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
      tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 2'd1};
      tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 2'd2};
      tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
      tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
      tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
      tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 2'd0};
      tbl[7]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
      tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 2'd1};
      tbl[9]  = '{4'b1010, 1'b0, 4'b1000, 2'd3};
      tbl[10] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
      tbl[11] = '{4'b1001, 1'b0, 4'b0001, 2'd0};
      tbl[12] = '{4'b1001, 1'b0, 4'b1000, 2'd3};

      for (int i = 0; i < N; i++) pdata[i] = '0;
      req_valid = '0;
      req_last  = '1;
      fifo_full = 1'b0;
      reset     = 1'b1;
      @(posedge clock);
      #1;
      do_reset();

      for (int i = 0; i < 13; i++)
         step($sformatf("vec%0d", i), tbl[i].v, 4'b1111,
              tbl[i].f, tbl[i].er, tbl[i].eg);

      // Random traffic against a search-order reference model.
      do_reset();
      m_ptr = N - 1;
      for (int c = 0; c < 300; c++) begin
         v = 4'($urandom);
         f = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) pdata[i] = 8'($urandom);
         req_valid = v;
         req_last  = 4'($urandom);
         fifo_full = f;
         #2;
         eg = -1;
         for (int k = 1; k <= N; k++)
            if (eg < 0 && v[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
         if (f) eg = -1;
         er = (eg >= 0) ? 4'(1 << eg) : 4'b0000;
         ed = (eg >= 0) ? pdata[eg] : 8'h00;
`ifdef FIFO_ARB_LOCK_EN
         req_last = 4'b1111;
         #1;
`endif
         chk("rnd ready", 32'(req_ready), 32'(er));
         chk("rnd wr", 32'(fifo_wr), 32'(eg >= 0));
         chk("rnd gid", 32'(grant_id), 32'(eg >= 0 ? eg : 0));
         chk("rnd din", 32'(fifo_din), 32'(ed));
         @(posedge clock);
         #1;
         if (eg >= 0) m_ptr = eg;
      end

      // Fill a depth-16 FIFO from producers 1 and 3.
      do_reset();
      pdata[1]  = 8'hA1;
      pdata[3]  = 8'hB3;
      req_valid = 4'b1010;
      req_last  = 4'b1111;
      writes    = 0;
      for (int c = 0; c < 18; c++) begin
         fifo_full = (q.size() >= 16);
         #2;
         if (c >= 16) begin
            chk("full ready", 32'(req_ready), 32'h0);
            chk("full wr", 32'(fifo_wr), 32'h0);
         end
         if (fifo_wr) begin
            q.push_back(fifo_din);
            writes++;
         end
         @(posedge clock);
         #1;
      end
      chk("fill writes", 32'(writes), 32'd16);
      chk("fill q0", 32'(q[0]), 32'hA1);
      chk("fill q1", 32'(q[1]), 32'hB3);
      void'(q.pop_front());
      fifo_full = (q.size() >= 16);
      #2;
      chk("resume wr", 32'(fifo_wr), 32'h1);
      chk("resume din", 32'(fifo_din), 32'hA1);
      chk("resume ready", 32'(req_ready), 32'b0010);
      @(posedge clock);
      #1;

`ifdef FIFO_ARB_LOCK_EN
      do_reset();
      step("lk pre", 4'b0010, 4'b1111, 1'b0, 4'b0010, 2'd1);
      step("lk b1", 4'b0111, 4'b0000, 1'b0, 4'b0100, 2'd2);
      step("lk b2", 4'b0111, 4'b0000, 1'b0, 4'b0100, 2'd2);
      step("lk gap", 4'b0011, 4'b0000, 1'b0, 4'b0000, 2'd0);
      step("lk b3", 4'b0111, 4'b0100, 1'b0, 4'b0100, 2'd2);
      step("lk nx3", 4'b1011, 4'b1111, 1'b0, 4'b1000, 2'd3);
      step("lk nx0", 4'b0011, 4'b1111, 1'b0, 4'b0001, 2'd0);
      step("lk re1", 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2);
      reset = 1'b1;
      step("lk rst", 4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0);
      reset = 1'b0;
      step("lk post", 4'b1111, 4'b1111, 1'b0, 4'b0001, 2'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one single-clock fall-ahead `fifo` write port among `N_REQ` producers. Each producer presents a valid/ready stream. The arbiter picks one eligible producer per cycle, steers its data onto `din`/`wr`, and never issues a write while the FIFO reports `full`. It sits directly in front of the `fifo` instance, and its outputs connect straight to that instance's `wr`, `din` and `full`.

## Interface
- `N_REQ`, 4: number of producers, ≥2, power of two
- `N_REQ_l`, 2: log2(`N_REQ`)
- `WIDTH`, 8: data width; must equal the FIFO's `WIDTH`
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  `N_REQ`  producer i has a word
- `req_data`  in  `N_REQ*WIDTH`  producer i word at bits [i*WIDTH +: WIDTH]
- `req_last`  in  `N_REQ`  last word of producer i packet (used only with `FIFO_ARB_LOCK_EN`)
- `req_ready`  out  `N_REQ`  one-hot or zero; producer i word accepted this cycle when valid & ready
- `fifo_full`  in  1  FIFO `full`
- `fifo_wr`  out  1  FIFO `wr`
- `fifo_din`  out  `WIDTH`  FIFO `din`
- `grant_id`  out  `N_REQ_l`  index of the granted producer; 0 when no grant
- `grant_valid`  out  1  a transfer occurs this cycle

## Operation
- State `rr_ptr` (`N_REQ_l` bits) holds the last granted index. Reset value is `N_REQ`-1, so producer 0 has highest priority first.
- Search order each cycle: `rr_ptr`+1, `rr_ptr`+2, … modulo `N_REQ`. The first index with `req_valid` set is the candidate `g`.
- If `fifo_full`=0 and a candidate exists:
  - `req_ready[g]`=1
  - `fifo_wr`=1
  - `fifo_din`=`req_data[g]`
  - `grant_id`=g
  - `grant_valid`=1
- Otherwise all of `req_ready`, `fifo_wr`, `fifo_din`, `grant_id` and `grant_valid` are 0.
- On each transfer, `rr_ptr` <= g. Without lock the pointer advances every beat, giving word-level fairness.
- `fifo_full`=1 stalls everyone. No word is lost and no `req_ready` is asserted.
- While `reset`=1, all outputs are forced to 0 regardless of inputs, and the state is cleared.

## Timing
- Zero-cycle latency: `req_ready`, `fifo_wr` and `fifo_din` are combinational from `req_valid`, `fifo_full` and registered state. Registered state is `rr_ptr`, plus the lock state when that feature is compiled in.
- The word is written into the FIFO at the same rising edge at which the producer sees valid&ready. It appears on the FIFO `dout` the next cycle (fall-ahead).
- Producers must hold `req_valid` and `req_data` until accepted. The arbiter may change the grant only at the edge after a transfer, or when the current candidate drops `req_valid`.
- Simultaneous full deassert and multiple valids: the grant goes to the rotation winner in that same cycle.
- Wrap: `rr_ptr`=`N_REQ`-1 searches from 0.

## Configuration
- `FIFO_ARB_LOCK_EN` defined: packet lock.
  - Adds state IDLE/LOCK and register `lock_id`.
  - IDLE, transfer with `req_last[g]`=0: go to LOCK with `lock_id`=g. `rr_ptr` is not updated.
  - LOCK: only `lock_id` is eligible. If it drops valid, nobody is granted; other producers wait even when the FIFO has space.
  - LOCK, transfer with `req_last`=1: go to IDLE with `rr_ptr`=`lock_id`.
  - IDLE, transfer with `req_last`=1: single-beat packet; behaves as in the non-lock case.
  - `reset` mid-packet returns to IDLE. The partial packet already in the FIFO is not removed.
- Not defined:
  - `req_last` is ignored.
  - No LOCK state and no `lock_id` register.
  - Arbitration is per word.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_LOCK`)
  - the reset constant for `rr_ptr`
- Sub-module `rr_pick`: combinational rotating priority encoder (`req` vector, `base` index → `gnt_id`, `gnt_any`), parameterised by `N_REQ` and `N_REQ_l`. It is instantiated once.

## Test plan
- After reset, `req_valid`=4'b1111, `fifo_full`=0, 4 cycles → grants 0,1,2,3. Data 0x10,0x11,0x12,0x13 read from the FIFO in that order.
- `req_valid`=4'b0100 only, `rr_ptr`=2 → repeated grants to 2 every cycle; `rr_ptr` stays 2.
- `fifo_full`=1 with all valid → `req_ready`=0, `fifo_wr`=0. Deassert full → grant resumes from `rr_ptr`+1.
- Fill a DEPTH=16 FIFO from producers 1 and 3 alternately → exactly 16 writes. The 17th is held, with `req_ready`=0 and the data held, until one read occurs.
- With `FIFO_ARB_LOCK_EN`: producer 2 sends 3 beats (last on beat 3) while 0 and 1 are valid. There is a 1-cycle gap on producer 2 mid-packet → no grant in the gap. After the last beat, the grant goes to 3 if valid, else 0.
- Reset asserted while in LOCK → all outputs 0. After release, the grant goes to 0.
